ram_stream_reader: RTL



---
 rtl/ram_stream_reader.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: RAM read-port sequencer feeding a valid/ready stream.
// Optional abort input when RAM_STREAM_READER_ABORT_EN is defined.
module ram_stream_reader #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 9,
    parameter int LWIDTH = 10
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [LWIDTH-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [AWIDTH-1:0] ram_addr,
    input  logic [DWIDTH-1:0] ram_dout,
    output logic              m_valid,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
`ifdef RAM_STREAM_READER_ABORT_EN
    ,
    input  logic              abort
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [LWIDTH-1:0] LONE = LWIDTH'(1);
    localparam logic [AWIDTH-1:0] AONE = AWIDTH'(1);

    logic [1:0]        state;
    logic [AWIDTH-1:0] addr;
    logic [LWIDTH-1:0] len_r;
    logic [LWIDTH-1:0] issued;
    logic [LWIDTH-1:0] popped;
    logic              inflight;
    logic [DWIDTH-1:0] fifo_mem [2];
    logic              wptr;
    logic              rptr;
    logic [1:0]        cnt;
    logic              done_r;

    logic              pop;
    logic              issue;
    logic              last_pop;
    logic              kill;
    logic [2:0]        occ;
    logic [2:0]        limit;

`ifdef RAM_STREAM_READER_ABORT_EN
    assign kill = abort & (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    assign pop      = m_valid & m_ready;
    assign last_pop = pop & m_last;

    // Occupancy seen by the next push: stored words plus the read in flight.
    assign occ   = {1'b0, cnt} + {2'b00, inflight};
    assign limit = 3'd2 + {2'b00, pop};
    assign issue = (state == READ) & ~kill & (issued < len_r) & (occ < limit);

    assign busy     = (state != IDLE);
    assign done     = done_r;
    assign ram_en   = issue;
    assign ram_addr = addr;
    assign m_valid  = (cnt != 2'd0);
    assign m_data   = fifo_mem[rptr];
    assign m_last   = m_valid & (popped == len_r - LONE);

    // Transfer sequencing: command capture, issue counting, completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            addr   <= '0;
            len_r  <= '0;
            issued <= '0;
            popped <= '0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (kill) begin
                state  <= IDLE;
                done_r <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && !done_r) begin
                            if (len != '0) begin
                                state  <= READ;
                                addr   <= base_addr;
                                len_r  <= len;
                                issued <= '0;
                                popped <= '0;
                            end else begin
                                done_r <= 1'b1;
                            end
                        end
                    end
                    READ: begin
                        if (issue && (issued == len_r - LONE)) begin
                            state <= DRAIN;
                        end
                    end
                    DRAIN: begin
                        if (last_pop) begin
                            state  <= IDLE;
                            done_r <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (issue) begin
                addr   <= addr + AONE;
                issued <= issued + LONE;
            end
            if (pop) begin
                popped <= popped + LONE;
            end
        end
    end

    // Two-entry FIFO absorbing the one-cycle RAM read latency.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight    <= 1'b0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            cnt         <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else if (kill) begin
            inflight <= 1'b0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            cnt      <= 2'd0;
        end else begin
            inflight <= issue;
            if (inflight) begin
                fifo_mem[wptr] <= ram_dout;
                wptr           <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
            end
            cnt <= cnt + {1'b0, inflight} - {1'b0, pop};
        end
    end

endmodule
